hazard_stall_controller: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS core. It works alongside the ALU-ALU forwarding logic and resolves the hazards that forwarding cannot:
- load-use stalls;
- structural/data stalls against the multi-cycle multiply/divide unit (MDU) and HI/LO;
- control flushes on taken branches.
It drives the PC/IF_ID write enables and the bubble/flush controls, and it owns the MDU busy counter.

---
 rtl/hazard_pkg.sv | 18 +
 rtl/mdu_cycle_counter.sv | 27 ++
 rtl/hazard_stall_controller.sv | 105 ++++++++++
 tb/tb_hazard_stall_controller.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/stall controller.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } state_t;

  localparam int unsigned MULT_CYCLES_DEF = 4;
  localparam int unsigned DIV_CYCLES_DEF  = 32;
  localparam int unsigned STATS_W         = 16;

  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v,
                                                 input logic                en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/mdu_cycle_counter.sv
// Busy timer for the multi-cycle MDU: loaded at issue, counts down while busy.
module mdu_cycle_counter #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             busy,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (busy && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = busy && (cnt == '0);

endmodule

// File: rtl/hazard_stall_controller.sv
// Load-use / MDU stall and branch flush sequencing for the 5-stage core.
// Optional HAZARD_STATS_EN adds saturating stall/flush event counters.
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] IF_ID_rs,
  input  logic [4:0] IF_ID_rt,
  input  logic       ID_uses_rt,
  input  logic [4:0] ID_EX_rt,
  input  logic       ID_EX_MemRead,
  input  logic       ID_is_mdu,
  input  logic       ID_is_div,
  input  logic       ID_reads_hilo,
  input  logic       EX_branch_taken,
  output logic       PCWrite,
  output logic       IF_ID_Write,
  output logic       IF_ID_Flush,
  output logic       ID_EX_Flush,
  output logic       mdu_start,
  output logic       mdu_busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [STATS_W-1:0] load_stall_cnt,
  output logic [STATS_W-1:0] mdu_stall_cnt,
  output logic [STATS_W-1:0] flush_cnt
`endif
);

  state_t           state;
  state_t           state_nx;
  logic             load_hz;
  logic             mdu_hz;
  logic             stall;
  logic             branch;
  logic             cnt_done;
  logic [CNT_W-1:0] cnt_load_val;

  assign load_hz = ID_EX_MemRead && (ID_EX_rt != 5'd0) &&
                   ((ID_EX_rt == IF_ID_rs) || (ID_uses_rt && (ID_EX_rt == IF_ID_rt)));
  assign mdu_hz  = (state == MDU_BUSY) && (ID_is_mdu || ID_reads_hilo);

  // Outputs are forced to their reset values while rst is held, regardless of inputs.
  assign branch  = EX_branch_taken && !rst;
  assign stall   = (load_hz || mdu_hz) && !EX_branch_taken && !rst;

  always_comb begin
    PCWrite     = !stall;
    IF_ID_Write = !stall;
    IF_ID_Flush = branch;
    ID_EX_Flush = stall || branch;
    mdu_start   = (state == RUN) && ID_is_mdu && !load_hz && !EX_branch_taken && !rst;
    mdu_busy    = (state == MDU_BUSY) && !rst;
  end

  assign cnt_load_val = ID_is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);

  mdu_cycle_counter #(
    .CNT_W(CNT_W)
  ) u_mdu_cycle_counter (
    .clk     (clk),
    .rst     (rst),
    .load    (mdu_start),
    .load_val(cnt_load_val),
    .busy    (state == MDU_BUSY),
    .done    (cnt_done)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      RUN:      if (mdu_start) state_nx = MDU_BUSY;
      MDU_BUSY: if (cnt_done)  state_nx = RUN;
      default:  state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nx;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_stall_cnt <= '0;
      mdu_stall_cnt  <= '0;
      flush_cnt      <= '0;
    end else begin
      load_stall_cnt <= sat_inc(load_stall_cnt, stall && load_hz);
      mdu_stall_cnt  <= sat_inc(mdu_stall_cnt, stall && mdu_hz && !load_hz);
      flush_cnt      <= sat_inc(flush_cnt, EX_branch_taken);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed + random bench for hazard_stall_controller against a cycle-count model.
module tb_hazard_stall_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs = '0, rt = '0, ex_rt = '0;
  logic       uses_rt = 1'b0, memread = 1'b0, is_mdu = 1'b0, is_div = 1'b0;
  logic       hilo = 1'b0, br = 1'b0;
  logic       PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, mdu_start, mdu_busy;

  int n_asserts = 0;
  int n_fail    = 0;
  int busy_left = 0;   // remaining MDU busy cycles, model side
  logic last_pcw, last_busy;

  always #5 clk = ~clk;

  hazard_stall_controller #(
    .MULT_CYCLES(4),
    .DIV_CYCLES (32),
    .CNT_W      (6)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .IF_ID_rs       (rs),
    .IF_ID_rt       (rt),
    .ID_uses_rt     (uses_rt),
    .ID_EX_rt       (ex_rt),
    .ID_EX_MemRead  (memread),
    .ID_is_mdu      (is_mdu),
    .ID_is_div      (is_div),
    .ID_reads_hilo  (hilo),
    .EX_branch_taken(br),
    .PCWrite        (PCWrite),
    .IF_ID_Write    (IF_ID_Write),
    .IF_ID_Flush    (IF_ID_Flush),
    .ID_EX_Flush    (ID_EX_Flush),
    .mdu_start      (mdu_start),
    .mdu_busy       (mdu_busy)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_asserts++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Check outputs mid-cycle against the rules, then advance one clock.
  task automatic step();
    logic bsy, lhz, mhz, stl, st;
    int   nxt;
    #2;
    if (rst) busy_left = 0;
    bsy = busy_left > 0;
    lhz = memread && (ex_rt != 0) && (ex_rt == rs || (uses_rt && ex_rt == rt));
    mhz = bsy && (is_mdu || hilo);
    stl = (lhz || mhz) && !br;
    st  = !bsy && is_mdu && !lhz && !br;
    if (rst) begin
      stl = 1'b0; st = 1'b0; bsy = 1'b0;
    end
    chk("PCWrite",     PCWrite,     !stl);
    chk("IF_ID_Write", IF_ID_Write, !stl);
    chk("IF_ID_Flush", IF_ID_Flush, br && !rst);
    chk("ID_EX_Flush", ID_EX_Flush, (stl || br) && !rst);
    chk("mdu_start",   mdu_start,   st);
    chk("mdu_busy",    mdu_busy,    bsy);
    last_pcw  = PCWrite;
    last_busy = mdu_busy;
    if (rst)      nxt = 0;
    else if (bsy) nxt = busy_left - 1;
    else if (st)  nxt = is_div ? 32 : 4;
    else          nxt = 0;
    @(posedge clk);
    #1;
    busy_left = nxt;
  endtask

  task automatic idle();
    rs = '0; rt = '0; ex_rt = '0; uses_rt = 1'b0; memread = 1'b0;
    is_mdu = 1'b0; is_div = 1'b0; hilo = 1'b0; br = 1'b0;
  endtask

  initial begin
    int cnt;
    // Reset held with a load-use hazard present
    idle();
    memread = 1'b1; ex_rt = 5'd8; rs = 5'd8;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    // Load-use stall, then cleared by the bubble
    step();
    memread = 1'b0;
    step();
    memread = 1'b1; ex_rt = 5'd0; rs = 5'd0;
    step();
    ex_rt = 5'd9; rs = 5'd1; rt = 5'd9; uses_rt = 1'b1;
    step();
    uses_rt = 1'b0;
    step();
    idle();

    // mult followed by mfhi waiting on HI/LO
    is_mdu = 1'b1;
    step();
    is_mdu = 1'b0; hilo = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (!last_pcw) cnt++;
    end
    chk_int("mfhi_stall_cycles", cnt, 4);
    step();
    chk("mfhi_issue_pcw", last_pcw, 1'b1);
    idle();

    // div with independent instructions flowing
    is_mdu = 1'b1; is_div = 1'b1;
    step();
    idle();
    cnt = 0;
    for (int i = 0; i < 35; i++) begin
      if (i < 10) begin
        rs = 5'($urandom_range(1, 31)); rt = 5'($urandom_range(1, 31)); uses_rt = 1'b1;
      end else begin
        idle();
      end
      step();
      if (last_busy) cnt++;
    end
    chk_int("div_busy_cycles", cnt, 32);

    // Branch overrides load-use stall and squashes MDU issue
    memread = 1'b1; ex_rt = 5'd4; rs = 5'd4; br = 1'b1;
    step();
    idle();
    is_mdu = 1'b1; br = 1'b1;
    step();
    br = 1'b0; is_mdu = 1'b0;
    step();

    // Branch during busy does not abort; back-to-back mult
    is_mdu = 1'b1;
    step();
    is_mdu = 1'b0; br = 1'b1;
    step();
    br = 1'b0; is_mdu = 1'b1;
    repeat (6) step();
    idle();
    repeat (4) step();

    // Reset in the middle of a div
    is_mdu = 1'b1; is_div = 1'b1;
    step();
    idle();
    repeat (10) step();
    rst = 1'b1;
    #1;
    chk("rst_async_busy", mdu_busy, 1'b0);
    chk("rst_async_pcw", PCWrite, 1'b1);
    busy_left = 0;
    step();
    step();
    rst = 1'b0;
    is_mdu = 1'b1;
    step();
    is_mdu = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (last_busy) cnt++;
    end
    chk_int("post_rst_mult_busy", cnt, 4);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rs      = 5'($urandom_range(0, 3));
      rt      = 5'($urandom_range(0, 3));
      ex_rt   = 5'($urandom_range(0, 3));
      uses_rt = 1'($urandom_range(0, 1));
      memread = ($urandom_range(0, 3) == 0);
      is_mdu  = ($urandom_range(0, 5) == 0);
      is_div  = ($urandom_range(0, 3) == 0);
      hilo    = ($urandom_range(0, 4) == 0);
      br      = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
